// File: rtl/dt_pkg.sv
// Shared types and geometry for the 128x128 distance-transform sequencer.
package dt_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FWD  = 2'd1,
    BWD  = 2'd2,
    FIN  = 2'd3
  } dt_state_t;

  localparam int IMG_W     = 128;
  localparam int ROM_WORDS = 1024;
  localparam int RES_AW    = 14;
  localparam int STI_AW    = 10;
  localparam int PIX_W     = 8;
  localparam int SLOT_LEN  = 17;

endpackage

// File: rtl/dt_loader.sv
// Unpacks 16-pixel ROM words into 8-bit result-RAM pixels, one 17-cycle slot per word.
// DT_BORDER_CLEAR_EN forces the outermost image ring to zero.
module dt_loader
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [15:0]       sti_di,
  output logic [RES_AW-1:0] addr,
  output logic [PIX_W-1:0]  data,
  output logic              wr,
  output logic              load_done
);

  localparam logic [4:0]        LAST_SLOT = 5'(SLOT_LEN - 1);
  localparam logic [STI_AW-1:0] LAST_WORD = STI_AW'(ROM_WORDS - 1);
  localparam logic [6:0]        EDGE_MAX  = 7'(IMG_W - 1);

  logic [STI_AW-1:0] word;
  logic [4:0]        slot;
  logic [15:0]       held;
  logic [4:0]        k_ext;
  logic [3:0]        k;
  logic [15:0]       src;
  logic              pix;
  logic [6:0]        row;
  logic [6:0]        col;
  logic              border;

  always_ff @(posedge clk) begin
    if (!reset || !run || load_done) begin
      word <= '0;
      slot <= '0;
    end else if (slot == LAST_SLOT) begin
      slot <= '0;
      word <= word + 1'b1;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      held <= '0;
    end else if (run && slot == 5'd1) begin
      held <= sti_di;
    end
  end

  // Slot cycle 1 writes straight from the ROM bus, before the latch holds the word.
  assign k_ext = slot - 5'd1;
  assign k     = k_ext[3:0];
  assign src   = (slot == 5'd1) ? sti_di : held;
  assign pix   = src[4'd15 - k];

  assign row = word[9:3];
  assign col = {word[2:0], k};
  assign border = (row == 7'd0) || (row == EDGE_MAX) || (col == 7'd0) || (col == EDGE_MAX);

  always_comb begin
    sti_rd    = run && (slot == 5'd0);
    sti_addr  = run ? word : '0;
    wr        = run && (slot != 5'd0);
    addr      = wr ? {word, k} : '0;
    data      = '0;
`ifdef DT_BORDER_CLEAR_EN
    if (wr) data = {{(PIX_W-1){1'b0}}, pix && !border};
`else
    if (wr) data = {{(PIX_W-1){1'b0}}, pix};
`endif
    load_done = wr && (word == LAST_WORD) && (slot == LAST_SLOT);
  end

endmodule

// File: rtl/dt_seq_ctrl.sv
// Top sequencer: LOAD -> FWD -> BWD -> FIN, owning the single result-RAM port.
// Optional build macro: DT_BORDER_CLEAR_EN (zero border during load).
module dt_seq_ctrl
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [15:0]       sti_di,
  output logic [RES_AW-1:0] res_addr,
  output logic              res_wr,
  output logic              res_rd,
  output logic [PIX_W-1:0]  res_do,
  output logic              fwd_start,
  output logic              bwd_start,
  input  logic [RES_AW-1:0] fwd_addr,
  input  logic [RES_AW-1:0] bwd_addr,
  input  logic              fwd_wr,
  input  logic              fwd_rd,
  input  logic              bwd_wr,
  input  logic              bwd_rd,
  input  logic [PIX_W-1:0]  fwd_do,
  input  logic [PIX_W-1:0]  bwd_do,
  input  logic              fwd_done,
  input  logic              bwd_done,
  output logic              done
);

  dt_state_t state_q, state_d;

  logic              ld_run;
  logic [RES_AW-1:0] ld_addr;
  logic [PIX_W-1:0]  ld_data;
  logic              ld_wr;
  logic              load_done;

  assign ld_run = reset && (state_q == LOAD);

  dt_loader u_loader (
    .clk       (clk),
    .reset     (reset),
    .run       (ld_run),
    .sti_rd    (sti_rd),
    .sti_addr  (sti_addr),
    .sti_di    (sti_di),
    .addr      (ld_addr),
    .data      (ld_data),
    .wr        (ld_wr),
    .load_done (load_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // Engine done pulses only count in their own state; anything else is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_done) state_d = FWD;
      FWD:     if (fwd_done)  state_d = BWD;
      BWD:     if (bwd_done)  state_d = FIN;
      FIN:     state_d = FIN;
      default: state_d = LOAD;
    endcase
  end

  // RAM port strobes (res_wr/res_rd) are single-cycle commands with address and
  // data valid in the same cycle; no back-pressure exists on this port.
  always_comb begin
    res_addr  = '0;
    res_wr    = 1'b0;
    res_rd    = 1'b0;
    res_do    = '0;
    fwd_start = 1'b0;
    bwd_start = 1'b0;
    done      = 1'b0;
    if (reset) begin
      case (state_q)
        LOAD: begin
          res_addr = ld_addr;
          res_wr   = ld_wr;
          res_do   = ld_data;
        end
        FWD: begin
          fwd_start = 1'b1;
          res_addr  = fwd_addr;
          res_wr    = fwd_wr;
          res_rd    = fwd_rd;
          res_do    = fwd_do;
        end
        BWD: begin
          bwd_start = 1'b1;
          res_addr  = bwd_addr;
          res_wr    = bwd_wr;
          res_rd    = bwd_rd;
          res_do    = bwd_do;
        end
        FIN:     done = 1'b1;
        default: done = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/dt_seq_ctrl.md
# dt_seq_ctrl

Top-level sequencer and RAM-port owner for the 128×128 distance-transform datapath. It unpacks the 1-bit-per-pixel source image from the stimulus ROM into the result RAM. It then runs the forward engine, then the backward engine, multiplexing the single result-RAM port between the loader and the two engines. It asserts `done` once the backward pass completes.

## Interface
- `IMG_W`, 128: image width and height in pixels.
- `ROM_WORDS`, 1024: 16-bit ROM words per image.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-low.
- `sti_rd` output 1: ROM read strobe.
- `sti_addr` output 10: ROM word address.
- `sti_di` input 16: ROM data, valid the cycle after `sti_rd`.
- `res_addr` output 14: result RAM address.
- `res_wr` output 1: RAM write enable.
- `res_rd` output 1: RAM read enable.
- `res_do` output 8: RAM write data.
- `fwd_start`, `bwd_start` output 1 each: engine run enables; each is level-high while its pass is active.
- `fwd_addr`, `bwd_addr` input 14 each: engine RAM address.
- `fwd_wr`, `fwd_rd`, `bwd_wr`, `bwd_rd` input 1 each: engine RAM strobes.
- `fwd_do`, `bwd_do` input 8 each: engine write data.
- `fwd_done`, `bwd_done` input 1 each: engine completion pulses.
- `done` output 1: transform complete; held high until reset.

## Operation
- FSM states: LOAD → FWD → BWD → FIN.
- Reset state is LOAD. All outputs are 0 during reset.
- LOAD: handles one 17-cycle slot per ROM word `w`.
  - Slot cycle 0: `sti_rd`=1, `sti_addr`=`w`.
  - Slot cycle 1: latch `sti_di`.
  - Slot cycles 1..16: write pixel `k`=0..15, with `res_addr`={`w`,`k[3:0]`} and `res_wr`=1.
  - Write data: `res_do`=8'h01 if bit (15−`k`) is set, else 8'h00. Bit 15 is the leftmost pixel.
  - In cycle 1 the write uses `sti_di` directly; cycles 2..16 use the latched word.
  - After word 1023 / k=15: go to FWD.
- FWD: `fwd_start`=1. The `res_*` outputs mirror the `fwd_*` inputs combinationally. On `fwd_done`=1: go to BWD on the next edge.
- BWD: `bwd_start`=1. The `res_*` outputs mirror the `bwd_*` inputs. On `bwd_done`=1: go to FIN.
- FIN: `done`=1, all RAM strobes 0, `res_addr`=0. FIN is terminal until reset.
- Arbitration is exclusive by state. An engine not selected is fully masked: its strobes never reach the RAM.
- Done pulses arriving outside their own state are ignored.
- `res_di` is shared by both engines and is not routed through this block.
- Counters: 10-bit word counter and 5-bit slot counter. Both clear on reset and on leaving LOAD; there is no wrap-around within LOAD.
- Reset mid-operation (any state): return to LOAD at word 0 next cycle, drop `fwd_start`/`bwd_start` and `done`, and restart the full image.

## Timing
- In LOAD, `res_rd`=0.
- Last LOAD write occurs at cycle 1024×17−1 = 17407 after reset release. `fwd_start` rises at cycle 17408.
- `fwd_start` falls, and `bwd_start` rises, on the edge following `fwd_done`. The done cycle itself is still muxed to the forward engine.
- `bwd_start` falls and `done` rises on the edge following `bwd_done`.
- Engine paths have zero latency: they are combinational muxes selected by registered state.
- All other outputs are registered or decoded from registered state.

## Configuration
- `DT_BORDER_CLEAR_EN` defined: during LOAD, pixels whose row or column is 0 or `IMG_W`−1 are written as 8'h00 regardless of the ROM bit.
  - Row = `w[9:3]`.
  - Column = {`w[2:0]`,`k[3:0]`}.
  - This lets the engines rely on a zero border.
- `DT_BORDER_CLEAR_EN` undefined: every pixel is written as its ROM bit.

## Structure
- Package `dt_pkg`:
  - State enum `dt_state_t` {LOAD, FWD, BWD, FIN}.
  - `IMG_W`=128, `ROM_WORDS`=1024, `RES_AW`=14, `STI_AW`=10, `PIX_W`=8, `SLOT_LEN`=17.
- Sub-module `dt_loader` holds the ROM read/unpack counter and the bit-select logic.
  - Outputs: address, data, write, and a `load_done` pulse.
  - The top level holds the FSM and the RAM-port mux.

## Test plan
- ROM word 0 = 16'h8001, all other words 0.
  - Expect writes of 01 to address 0 and 01 to address 15.
  - Expect writes of 00 to addresses 1..14.
  - `sti_rd` is high only in slot cycle 0.
- All-ones ROM with `DT_BORDER_CLEAR_EN`.
  - Expect 00 written at addresses 0, 127, 128, 16256, 16383.
  - Expect 01 written at address 129.
  - Without the macro, all five border addresses above receive 01.
- `fwd_done` held high during LOAD, then pulsed at FWD cycle 50.
  - Expect no early transition.
  - `bwd_start` rises exactly 1 cycle after the pulse.
- In FWD, drive `bwd_wr`=1 and `bwd_addr`=5.
  - Expect the RAM to see only `fwd_addr` and `fwd_wr`; the `bwd_*` write never reaches `res_*`.
- Assert `reset` during BWD.
  - Next cycle: `bwd_start`=0, `done`=0, `sti_rd`=1, `sti_addr`=0.
- Full run with `bwd_done` pulse.
  - `done` rises 1 cycle after the pulse and remains high for 100 cycles.
